// File: rtl/mips_mem_responder_if.sv
// rtl/mips_mem_responder_if.sv - request/response bus between MIPS memory port and responder
interface mips_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - word RAM responder with programmable wait states
module mips_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                 cclk,
    input  logic                 rstb,
    mips_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic              acc_we;
    logic [31:0]       acc_addr, acc_wdata;
    logic [3:0]        acc_wstrb;
    logic [ADDR_W-1:0] idx;
    logic              bad;
    logic              enter_resp;
    logic              mem_wr;

    // With zero latency RESP is entered on the accept edge itself, so the
    // live inputs stand in for the not-yet-captured copies while idle.
    always_comb begin
        if (state == S_IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_wstrb = bus.wstrb;
        end else begin
            acc_we    = cap_we;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
            acc_wstrb = cap_wstrb;
        end
        idx = acc_addr[ADDR_W+1:2];
        bad = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_nxt = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        mem_wr = enter_resp && acc_we && !bad;
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && bus.req) begin
                cap_we    <= bus.we;
                cap_addr  <= bus.addr;
                cap_wdata <= bus.wdata;
                cap_wstrb <= bus.wstrb;
            end
            if (enter_resp) begin
                err_q   <= bad;
                rdata_q <= (bad || acc_we) ? 32'd0 : mem[idx];
            end else if (state == S_RESP) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // RAM is not reset; the rstb gate keeps a reset edge from committing a write.
    always_ff @(posedge cclk) begin
        if (rstb && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign bus.ready = (state == S_RESP);
    assign bus.busy  = (state != S_IDLE);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
